// File: rtl/weight_fifo_sched.sv
// Weight FIFO scheduler: fills every column FIFO with one weight tile read from
// the weight buffer, then drains the tile into the systolic array. Each column
// starts popping one cycle after the column to its left.
module weight_fifo_sched #(
   parameter int unsigned FIFO_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_req,
   input  logic [ADDR_WIDTH-1:0] load_base,
   output logic                  load_ack,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [FIFO_WIDTH-1:0] fifo_push,
   output logic                  tile_ready,
   input  logic                  drain_req,
   output logic [FIFO_WIDTH-1:0] fifo_pop,
   output logic                  drain_done,
   output logic                  busy
);

   // The counter must reach FIFO_DEPTH+FIFO_WIDTH-2 during drain; one spare bit
   // keeps the increment past the last value from wrapping.
   localparam int unsigned CW = $clog2(FIFO_DEPTH + FIFO_WIDTH) + 1;
   localparam logic [CW-1:0] FillLast  = CW'(FIFO_DEPTH - 1);
   localparam logic [CW-1:0] DrainLast = CW'(FIFO_DEPTH + FIFO_WIDTH - 2);

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StFlush,
      StReady,
      StDrain
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   // Delayed copy of rd_en; the oldest bit marks the cycle the read data returns.
   logic [RD_LAT-1:0]     pipe_q, pipe_d;
   logic [FIFO_WIDTH-1:0] pop_d;

   // Accept is combinational so the requester sees it in the cycle it asks.
   assign load_ack  = ~rst & (state_q == StIdle) & load_req;
   assign fifo_push = {FIFO_WIDTH{pipe_q[RD_LAT-1]}};

   // Next-state logic for state, counter, base latch, read-latency pipe and pop mask
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      pipe_d  = '0;
      pop_d   = '0;

      pipe_d[0] = rd_en;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end

      unique case (state_q)
         StIdle: begin
            if (load_req) begin
               base_d  = load_base;
               cnt_d   = '0;
               state_d = StFill;
            end
         end
         StFill: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == FillLast) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            // Leave once the last outstanding read has been pushed.
            if (pipe_d == '0) begin
               state_d = StReady;
            end
         end
         StReady: begin
            if (drain_req) begin
               cnt_d   = '0;
               state_d = StDrain;
            end
         end
         StDrain: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == DrainLast) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Column c pops on drain cycles c .. c+FIFO_DEPTH-1.
      for (int c = 0; c < int'(FIFO_WIDTH); c++) begin
         pop_d[c] = (state_d == StDrain) && (int'(cnt_d) >= c) &&
                    (int'(cnt_d) <= c + int'(FIFO_DEPTH) - 1);
      end
   end

   // State registers and registered outputs, cleared asynchronously on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         base_q     <= '0;
         pipe_q     <= '0;
         rd_en      <= 1'b0;
         rd_addr    <= '0;
         tile_ready <= 1'b0;
         fifo_pop   <= '0;
         drain_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         base_q     <= base_d;
         pipe_q     <= pipe_d;
         rd_en      <= (state_d == StFill);
         // Address arithmetic wraps modulo the buffer size.
         rd_addr    <= (state_d == StFill) ? base_d + ADDR_WIDTH'(cnt_d) : '0;
         tile_ready <= (state_d == StReady);
         fifo_pop   <= pop_d;
         drain_done <= (state_d == StDrain) && (cnt_d == DrainLast);
         busy       <= (state_d != StIdle);
      end
   end

endmodule

// File: tb/tb_weight_fifo_sched.sv
// Bench for weight_fifo_sched: a tile-level reference model predicts every output
// each cycle; a table of tile scenarios checks latencies and address ranges.
module tb_weight_fifo_sched;

   localparam int D = 16;
   localparam int W = 16;
   localparam int A = 10;
   localparam int L = 2;

   logic         clk;
   logic         rst;
   logic         load_req;
   logic [A-1:0] load_base;
   logic         load_ack;
   logic         rd_en;
   logic [A-1:0] rd_addr;
   logic [W-1:0] fifo_push;
   logic         tile_ready;
   logic         drain_req;
   logic [W-1:0] fifo_pop;
   logic         drain_done;
   logic         busy;

   weight_fifo_sched #(
      .FIFO_WIDTH(W),
      .FIFO_DEPTH(D),
      .ADDR_WIDTH(A),
      .RD_LAT    (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load_req  (load_req),
      .load_base (load_base),
      .load_ack  (load_ack),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .fifo_push (fifo_push),
      .tile_ready(tile_ready),
      .drain_req (drain_req),
      .fifo_pop  (fifo_pop),
      .drain_done(drain_done),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // Reference model: phase 0 idle, 1 loading, 2 tile ready, 3 draining.
   int           m_phase = 0;
   int           m_e     = 0;   // cycles since accept while loading (1 = first read)
   int           m_d     = 0;   // drain cycle index
   logic [A-1:0] m_base  = '0;

   int push_cnt[W];
   int pop_cnt[W];

   // Observed outputs from the most recent step.
   logic         o_ack, o_rd_en, o_ready, o_done;
   logic [A-1:0] o_addr;

   typedef struct {
      logic [A-1:0] base;
      int           ready_wait;
      bit           early_drain;
      bit           hold_req;
      logic [A-1:0] exp_first;
      logic [A-1:0] exp_last;
      int           exp_fill_to_ready;
      int           exp_drain_len;
   } tile_vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pack_dut();
      return {17'd0, load_ack, rd_en, (rd_en ? rd_addr : {A{1'b0}}), fifo_push, tile_ready,
              fifo_pop, drain_done, busy};
   endfunction

   task automatic clear_sb();
      for (int c = 0; c < W; c++) begin
         push_cnt[c] = 0;
         pop_cnt[c]  = 0;
      end
   endtask

   // One clock cycle: drive inputs, compare all outputs to the model, advance the model.
   task automatic step(input logic lr, input logic [A-1:0] lb, input logic dr);
      logic         e_ack, e_rd, e_ready, e_done, e_busy;
      logic [A-1:0] e_addr;
      logic [W-1:0] e_push, e_pop;
      int           bad_push, bad_pop;
      @(negedge clk);
      load_req  = lr;
      load_base = lb;
      drain_req = dr;
      #1;
      e_ack   = (m_phase == 0) && lr;
      e_rd    = (m_phase == 1) && (m_e <= D);
      e_addr  = e_rd ? A'(int'(m_base) + m_e - 1) : '0;
      e_push  = ((m_phase == 1) && (m_e >= L + 1)) ? {W{1'b1}} : '0;
      e_ready = (m_phase == 2);
      e_done  = (m_phase == 3) && (m_d == D + W - 2);
      e_busy  = (m_phase != 0);
      for (int c = 0; c < W; c++) begin
         e_pop[c] = (m_phase == 3) && (m_d >= c) && (m_d <= c + D - 1);
      end
      check("cycle_outputs", pack_dut(),
            {17'd0, e_ack, e_rd, e_addr, e_push, e_ready, e_pop, e_done, e_busy});

      o_ack   = load_ack;
      o_rd_en = rd_en;
      o_addr  = rd_addr;
      o_ready = tile_ready;
      o_done  = drain_done;

      for (int c = 0; c < W; c++) begin
         push_cnt[c] += int'(fifo_push[c]);
         pop_cnt[c]  += int'(fifo_pop[c]);
      end
      if (e_done) begin
         bad_push = 0;
         bad_pop  = 0;
         for (int c = 0; c < W; c++) begin
            if (push_cnt[c] != D) bad_push++;
            if (pop_cnt[c] != D) bad_pop++;
         end
         check("sb_push_bad_columns", 64'(bad_push), 64'd0);
         check("sb_pop_bad_columns", 64'(bad_pop), 64'd0);
         clear_sb();
      end

      case (m_phase)
         0: if (lr) begin m_phase = 1; m_e = 1; m_base = lb; end
         1: if (m_e == L + D) m_phase = 2; else m_e++;
         2: if (dr) begin m_phase = 3; m_d = 0; end
         3: if (m_d == D + W - 2) m_phase = 0; else m_d++;
         default: m_phase = 0;
      endcase
   endtask

   // Asynchronous reset in the middle of a cycle, released on a falling edge.
   task automatic mid_reset();
      #2;
      load_req  = 1'b0;
      drain_req = 1'b0;
      rst       = 1'b1;
      #1;
      check("async_reset_outputs", pack_dut(), 64'd0);
      @(posedge clk);
      #1;
      check("reset_hold_outputs", pack_dut(), 64'd0);
      @(negedge clk);
      rst     = 1'b0;
      m_phase = 0;
      clear_sb();
   endtask

   task automatic run_tile(input tile_vec_t v);
      int           n, t_ready, t_drain, acks;
      bit           got, seen;
      logic [A-1:0] first_a, last_a;
      n   = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         step(1'b1, v.base, v.early_drain);
         got = o_ack;
         n++;
      end
      check("req_to_ack", 64'(n), 64'd1);
      acks    = 1;
      seen    = 1'b0;
      first_a = '0;
      last_a  = '0;
      t_ready = 0;
      got     = 1'b0;
      while (!got && t_ready < 100) begin
         step(v.hold_req, v.base ^ 10'h155, v.early_drain);
         t_ready++;
         if (o_rd_en) begin
            if (!seen) first_a = o_addr;
            seen   = 1'b1;
            last_a = o_addr;
         end
         if (o_ack) acks++;
         got = o_ready;
      end
      check("fill_to_ready", 64'(t_ready), 64'(v.exp_fill_to_ready));
      check("first_rd_addr", 64'(first_a), 64'(v.exp_first));
      check("last_rd_addr", 64'(last_a), 64'(v.exp_last));
      if (!v.early_drain) begin
         for (int i = 0; i < v.ready_wait; i++) begin
            step(v.hold_req, v.base, 1'b0);
            if (o_ack) acks++;
         end
         step(v.hold_req, v.base, 1'b1);
         if (o_ack) acks++;
      end
      t_drain = 0;
      got     = 1'b0;
      while (!got && t_drain < 100) begin
         step(v.hold_req, v.base, 1'b0);
         t_drain++;
         if (o_ack) acks++;
         got = o_done;
      end
      check("drain_len", 64'(t_drain), 64'(v.exp_drain_len));
      check("acks_per_tile", 64'(acks), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tile_vec_t vecs[4];
      int        n;
      vecs[0] = '{10'h010, 0, 1'b0, 1'b0, 10'h010, 10'h01F, 19, 31};
      vecs[1] = '{10'h3F8, 3, 1'b0, 1'b1, 10'h3F8, 10'h007, 19, 31};
      vecs[2] = '{10'h3FF, 0, 1'b1, 1'b1, 10'h3FF, 10'h00E, 19, 31};
      vecs[3] = '{10'h200, 2, 1'b0, 1'b0, 10'h200, 10'h20F, 19, 31};

      rst       = 1'b1;
      load_req  = 1'b0;
      load_base = '0;
      drain_req = 1'b0;
      clear_sb();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", pack_dut(), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Idle, then drain requests while idle must not pop.
      step(1'b0, '0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b1);

      // Abort mid-fill at counter value 7 while requests are held.
      step(1'b1, 10'h123, 1'b0);
      repeat (8) step(1'b1, 10'h123, 1'b1);
      mid_reset();
      step(1'b0, '0, 1'b0);

      // Abort mid-drain.
      step(1'b1, 10'h040, 1'b0);
      n = 0;
      while (!o_ready && n < 60) begin
         step(1'b0, 10'h040, 1'b0);
         n++;
      end
      check("ready_before_drain_abort", 64'(o_ready), 64'd1);
      step(1'b0, 10'h040, 1'b1);
      repeat (10) step(1'b0, 10'h040, 1'b0);
      mid_reset();
      step(1'b0, '0, 1'b0);

      // Scenario table.
      for (int i = 0; i < 4; i++) begin
         run_tile(vecs[i]);
      end

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) == 0), A'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
